// File: rtl/nv_ram_rws_fifo_ctrl_64x116_if.sv
// Producer/consumer handshake bundle for the 64x116 RAM-backed FIFO controller.
// Latency: n/a (wires only).
// Backpressure: wr_prdy / rd_prdy carry ready in each direction.
interface nv_ram_rws_fifo_ctrl_64x116_if #(
    parameter int AW = 6,
    parameter int DW = 116
);
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic [AW:0]   fifo_count;

    // Traffic source/sink side (producer + consumer)
    modport master (
        output wr_pvld, wr_pd, rd_prdy,
        input  wr_prdy, rd_pvld, rd_pd, fifo_count
    );

    // FIFO controller side
    modport slave (
        input  wr_pvld, wr_pd, rd_prdy,
        output wr_prdy, rd_pvld, rd_pd, fifo_count
    );
endinterface

// File: rtl/nv_ram_rws_fifo_ctrl_64x116.sv
// Valid/ready FIFO controller driving both ports of an external 64x116 registered-read RAM.
// Latency: a word accepted into an empty FIFO is presented on rd_pvld two edges later; 1 word/cycle sustained.
// Backpressure: wr_prdy drops when the RAM holds DEPTH words; a 2-entry skid hides the RAM read latency from rd_prdy.
module nv_ram_rws_fifo_ctrl_64x116 #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 116
) (
    input  logic                             nvdla_core_clk,
    input  logic                             nvdla_core_rstn,
    nv_ram_rws_fifo_ctrl_64x116_if.slave     fifo,
    output logic                             ram_we,
    output logic [AW-1:0]                    ram_wa,
    output logic [DW-1:0]                    ram_di,
    output logic                             ram_re,
    output logic [AW-1:0]                    ram_ra,
    input  logic [DW-1:0]                    ram_dout,
    input  logic [31:0]                      pwrbus_ram_pd,
    output logic [31:0]                      ram_pwrbus_ram_pd
);

    localparam logic [AW:0]   RAM_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   ram_cnt_nxt;
    logic          rd_inflight;
    logic [1:0]    skid_cnt;
    logic [1:0]    skid_cnt_nxt;
    logic [DW-1:0] skid_head;
    logic [DW-1:0] skid_tail;
    logic [AW:0]   fifo_count_q;
    logic [AW:0]   fifo_count_nxt;
    logic [2:0]    skid_occ;
    logic          accept;
    logic          pop;
    logic          issue;
    logic          load;

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    // Write side: ready is held low during reset; the count is the pre-issue value so a
    // write can never land on the slot being read at the same edge.
    assign fifo.wr_prdy = nvdla_core_rstn & (ram_cnt < RAM_FULL);
    assign accept       = fifo.wr_pvld & fifo.wr_prdy;
    assign ram_we       = accept;
    assign ram_wa       = wr_ptr;
    assign ram_di       = fifo.wr_pd;

    // Read side: issue only when the word will have a skid slot by the time it lands.
    assign pop      = fifo.rd_pvld & fifo.rd_prdy;
    assign load     = rd_inflight;
    assign skid_occ = {1'b0, skid_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign issue    = (ram_cnt != '0) && (skid_occ < 3'd2);
    assign ram_re   = issue;
    assign ram_ra   = rd_ptr;

    assign fifo.rd_pvld    = (skid_cnt != 2'd0);
    assign fifo.rd_pd      = skid_head;
    assign fifo.fifo_count = fifo_count_q;

    // Next-state occupancy for the RAM and the skid buffer
    always_comb begin
        ram_cnt_nxt  = ram_cnt;
        skid_cnt_nxt = skid_cnt;
        case ({accept, issue})
            2'b10:   ram_cnt_nxt = ram_cnt + CNT_ONE;
            2'b01:   ram_cnt_nxt = ram_cnt - CNT_ONE;
            default: ram_cnt_nxt = ram_cnt;
        endcase
        case ({load, pop})
            2'b10:   skid_cnt_nxt = skid_cnt + 2'd1;
            2'b01:   skid_cnt_nxt = skid_cnt - 2'd1;
            default: skid_cnt_nxt = skid_cnt;
        endcase
    end

    assign fifo_count_nxt = ram_cnt_nxt
                          + {{AW{1'b0}}, issue}
                          + {{(AW-1){1'b0}}, skid_cnt_nxt};

    // Pointers, counters and the in-flight read flag
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_cnt      <= '0;
            rd_inflight  <= 1'b0;
            skid_cnt     <= 2'd0;
            fifo_count_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            ram_cnt      <= ram_cnt_nxt;
            rd_inflight  <= issue;
            skid_cnt     <= skid_cnt_nxt;
            fifo_count_q <= fifo_count_nxt;
        end
    end

    // Skid buffer: head is the consumer-visible word, tail holds the next one
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            skid_head <= '0;
            skid_tail <= '0;
        end else begin
            case ({load, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) begin
                        skid_head <= ram_dout;
                    end else begin
                        skid_tail <= ram_dout;
                    end
                end
                2'b01: begin
                    skid_head <= skid_tail;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid_head <= ram_dout;
                    end else begin
                        skid_head <= skid_tail;
                        skid_tail <= ram_dout;
                    end
                end
                default: begin
                    skid_head <= skid_head;
                end
            endcase
        end
    end

    a_ram_cnt_bound: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        ram_cnt <= RAM_FULL);

    a_load_has_slot: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !(load && !pop && (skid_cnt == 2'd2)));

endmodule

// File: tb/tb_nv_ram_rws_fifo_ctrl_64x116.sv
// Bench for the 64x116 RAM-backed FIFO controller with a behavioural registered-read RAM.
// Latency: checks the two-edge empty-FIFO latency and 1 word/cycle streaming.
// Backpressure: exercises full (66 words), drain, random ready and mid-operation reset.
module tb_nv_ram_rws_fifo_ctrl_64x116;
    localparam int DW = 116;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [31:0]   pwrbus_ram_pd;
    logic [31:0]   ram_pwrbus_ram_pd;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] sb[$];
    logic [AW-1:0] wp_model;

    always #5 clk = ~clk;

    nv_ram_rws_fifo_ctrl_64x116_if #(.AW(AW), .DW(DW)) bus ();

    nv_ram_rws_fifo_ctrl_64x116 dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .fifo              (bus.slave),
        .ram_we            (ram_we),
        .ram_wa            (ram_wa),
        .ram_di            (ram_di),
        .ram_re            (ram_re),
        .ram_ra            (ram_ra),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
    );

    // Behavioural RAM: write at the edge, read address registered, data combinational on it
    logic [DW-1:0] mem [64];
    logic [AW-1:0] ra_d;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
    end
    assign ram_dout = mem[ra_d];

    task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr);
        bus.wr_pvld = wv;
        bus.wr_pd   = wd;
        bus.rd_prdy = rr;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        pwrbus_ram_pd = 32'hDEAD_BEEF;
        drive(1'b0, '0, 1'b0);
        repeat (2) tick();
        drive(1'b1, 116'h1, 1'b1);
        n_cmp++; if (bus.wr_prdy !== 1'b0) begin n_err++; $display("FAIL rst_wr_prdy_low: got %0b want 0", bus.wr_prdy); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we_low: got %0b want 0", ram_we); end
        n_cmp++; if (ram_re !== 1'b0) begin n_err++; $display("FAIL rst_ram_re_low: got %0b want 0", ram_re); end
        drive(1'b0, '0, 1'b0);
        rstn = 1'b1;
        #1;
        n_cmp++; if (bus.rd_pvld !== 1'b0) begin n_err++; $display("FAIL rst_rd_pvld: got %0b want 0", bus.rd_pvld); end
        n_cmp++; if (bus.fifo_count !== 7'd0) begin n_err++; $display("FAIL rst_fifo_count: got %0d want 0", bus.fifo_count); end
        n_cmp++; if (bus.wr_prdy !== 1'b1) begin n_err++; $display("FAIL rst_wr_prdy: got %0b want 1", bus.wr_prdy); end
        n_cmp++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin n_err++; $display("FAIL rst_ram_ctl: got we=%0b re=%0b want 0 0", ram_we, ram_re); end
        n_cmp++; if (ram_pwrbus_ram_pd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pwrbus: got %h want deadbeef", ram_pwrbus_ram_pd); end
        wp_model = '0;
        tick();
    endtask

    task automatic test_single();
        drive(1'b1, 116'hA5, 1'b1);
        n_cmp++; if (ram_we !== 1'b1 || ram_wa !== 6'd0 || ram_di !== 116'hA5) begin n_err++; $display("FAIL single_write: got we=%0b wa=%0d di=%h want 1 0 a5", ram_we, ram_wa, ram_di); end
        wp_model++;
        tick();
        drive(1'b0, '0, 1'b1);
        n_cmp++; if (ram_re !== 1'b1 || ram_ra !== 6'd0) begin n_err++; $display("FAIL single_issue: got re=%0b ra=%0d want 1 0", ram_re, ram_ra); end
        n_cmp++; if (bus.rd_pvld !== 1'b0) begin n_err++; $display("FAIL single_early_c1: got rd_pvld=%0b want 0", bus.rd_pvld); end
        tick();
        drive(1'b0, '0, 1'b1);
        n_cmp++; if (bus.rd_pvld !== 1'b0 || bus.fifo_count !== 7'd1) begin n_err++; $display("FAIL single_c2: got rd_pvld=%0b cnt=%0d want 0 1", bus.rd_pvld, bus.fifo_count); end
        tick();
        drive(1'b0, '0, 1'b1);
        n_cmp++; if (bus.rd_pvld !== 1'b1 || bus.rd_pd !== 116'hA5) begin n_err++; $display("FAIL single_out: got rd_pvld=%0b rd_pd=%h want 1 a5", bus.rd_pvld, bus.rd_pd); end
        tick();
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (bus.rd_pvld !== 1'b0 || bus.fifo_count !== 7'd0) begin n_err++; $display("FAIL single_empty: got rd_pvld=%0b cnt=%0d want 0 0", bus.rd_pvld, bus.fifo_count); end
    endtask

    task automatic test_full_drain();
        int acc = 0;
        int pops = 0;
        logic [DW-1:0] exp;
        for (int c = 0; c < 70; c++) begin
            drive(1'b1, DW'(acc), 1'b0);
            if (bus.wr_prdy) begin
                n_cmp++; if (ram_wa !== wp_model) begin n_err++; $display("FAIL full_wa: got %0d want %0d", ram_wa, wp_model); end
                sb.push_back(bus.wr_pd);
                wp_model++;
                acc++;
            end
            tick();
        end
        drive(1'b1, DW'(acc), 1'b0);
        n_cmp++; if (acc != 66) begin n_err++; $display("FAIL full_accepts: got %0d want 66", acc); end
        n_cmp++; if (bus.wr_prdy !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL full_wr_prdy: got prdy=%0b we=%0b want 0 0", bus.wr_prdy, ram_we); end
        n_cmp++; if (bus.fifo_count !== 7'd66) begin n_err++; $display("FAIL full_count: got %0d want 66", bus.fifo_count); end
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            drive(1'b0, '0, 1'b1);
            if (bus.rd_pvld) begin
                exp = sb.pop_front();
                n_cmp++; if (bus.rd_pd !== exp || exp !== DW'(pops)) begin n_err++; $display("FAIL drain_data: got %h want %h", bus.rd_pd, exp); end
                pops++;
            end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (pops != 66 || sb.size() != 0) begin n_err++; $display("FAIL drain_count: got %0d want 66", pops); sb.delete(); end
        n_cmp++; if (bus.fifo_count !== 7'd0) begin n_err++; $display("FAIL drain_empty: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_back_to_back();
        int offered = 0, pops = 0, stalls = 0;
        int first_pop = -1, last_pop = -1;
        logic [DW-1:0] exp;
        for (int it = 0; it < 220 && pops < 200; it++) begin
            drive(offered < 200, DW'(1000 + offered), 1'b1);
            if (bus.wr_pvld && !bus.wr_prdy) stalls++;
            if (bus.wr_pvld && bus.wr_prdy) begin
                sb.push_back(bus.wr_pd);
                offered++;
            end
            if (bus.rd_pvld) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_unexpected: got %h want none", bus.rd_pd);
                end else begin
                    exp = sb.pop_front();
                    n_cmp++; if (bus.rd_pd !== exp) begin n_err++; $display("FAIL b2b_data: got %h want %h", bus.rd_pd, exp); end
                end
                if (first_pop < 0) first_pop = it;
                last_pop = it;
                pops++;
            end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (first_pop != 3) begin n_err++; $display("FAIL b2b_latency: got first pop at %0d want 3", first_pop); end
        n_cmp++; if (last_pop != 202 || pops != 200) begin n_err++; $display("FAIL b2b_bubbles: got last=%0d pops=%0d want 202 200", last_pop, pops); end
        n_cmp++; if (stalls != 0) begin n_err++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
        sb.delete();
    endtask

    task automatic test_random();
        int offered = 0, pops = 0;
        logic [DW-1:0] exp;
        for (int it = 0; it < 40000 && pops < 5000; it++) begin
            drive((offered < 5000) ? 1'($urandom_range(0, 1)) : 1'b0, rnd_word(), 1'($urandom_range(0, 1)));
            n_cmp++;
            if (int'(bus.fifo_count) != sb.size()) begin
                n_err++;
                if (n_err < 20) $display("FAIL rand_count: got %0d want %0d", bus.fifo_count, sb.size());
            end
            if (bus.wr_pvld && bus.wr_prdy) begin
                sb.push_back(bus.wr_pd);
                offered++;
            end
            if (bus.rd_pvld && bus.rd_prdy) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rand_unexpected: got %h want none", bus.rd_pd);
                end else begin
                    exp = sb.pop_front();
                    if (bus.rd_pd !== exp) begin
                        n_err++;
                        if (n_err < 20) $display("FAIL rand_data: got %h want %h", bus.rd_pd, exp);
                    end
                end
                pops++;
            end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (pops != 5000) begin n_err++; $display("FAIL rand_total: got %0d want 5000", pops); end
        sb.delete();
    endtask

    task automatic test_mid_reset();
        int seen = -1;
        logic [DW-1:0] exp;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, DW'(500 + c), 1'b0);
            if (bus.wr_prdy) sb.push_back(bus.wr_pd);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.rd_pvld !== 1'b0 || bus.rd_pd !== '0) begin n_err++; $display("FAIL mrst_rd: got pvld=%0b pd=%h want 0 0", bus.rd_pvld, bus.rd_pd); end
        n_cmp++; if (bus.fifo_count !== 7'd0) begin n_err++; $display("FAIL mrst_count: got %0d want 0", bus.fifo_count); end
        n_cmp++; if (bus.wr_prdy !== 1'b0 || ram_re !== 1'b0) begin n_err++; $display("FAIL mrst_ctl: got prdy=%0b re=%0b want 0 0", bus.wr_prdy, ram_re); end
        sb.delete();
        tick();
        rstn = 1'b1;
        drive(1'b1, 116'h3C, 1'b1);
        n_cmp++; if (ram_we !== 1'b1 || ram_wa !== 6'd0) begin n_err++; $display("FAIL mrst_wa: got we=%0b wa=%0d want 1 0", ram_we, ram_wa); end
        if (bus.wr_prdy) sb.push_back(bus.wr_pd);
        tick();
        for (int c = 0; c < 10 && seen < 0; c++) begin
            drive(1'b0, '0, 1'b1);
            if (bus.rd_pvld) begin
                seen = c;
                exp = (sb.size() != 0) ? sb.pop_front() : '1;
                n_cmp++; if (bus.rd_pd !== exp || exp !== 116'h3C) begin n_err++; $display("FAIL mrst_data: got %h want 3c", bus.rd_pd); end
            end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (seen != 2) begin n_err++; $display("FAIL mrst_latency: got %0d want 2", seen); end
        n_cmp++; if (bus.rd_pvld !== 1'b0 || bus.fifo_count !== 7'd0) begin n_err++; $display("FAIL mrst_after: got pvld=%0b cnt=%0d want 0 0", bus.rd_pvld, bus.fifo_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_drain();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
